// File: rtl/addsub_accum_ctrl.sv
// addsub_accum_ctrl: sequencing front-end for the external 8-bit adder/subtractor.
// Accepts ADD/SUB/LOAD/CLEAR commands, drives the adder during a one-cycle
// EXEC state, and captures the result into an 8-bit accumulator. Each updated
// value goes out over a valid/ready response stream. The block also keeps a
// saturating count of zero results.
// Optional feature: define ADDSUB_ACC_SAT_EN for saturating accumulate
// (ADD carry clamps to 0xFF, SUB borrow clamps to 0x00).
module addsub_accum_ctrl #(
    parameter int ZCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [7:0]        in_data,
    output logic              do_sub,
    output logic [7:0]        a,
    output logic [7:0]        b,
    input  logic [7:0]        sum,
    input  logic              sum_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_acc,
    output logic              out_zero,
    output logic              out_wrap,
    output logic [ZCNT_W-1:0] zero_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t            state;
    state_t            state_next;
    logic [1:0]        op_reg;
    logic [7:0]        operand;
    logic [7:0]        acc;
    logic              sub_reg;
    logic              zero_reg;
    logic              wrap_reg;
    logic [ZCNT_W-1:0] zcnt;

    logic              accept;
    logic              resp_done;
    logic [7:0]        acc_next;
    logic              zero_next;
    logic              wrap_next;

    // Ready is gated by reset so no command can be taken in the reset cycle.
    assign in_ready   = (state == IDLE) && !reset;
    assign out_valid  = (state == RESP);
    assign a          = acc;
    assign b          = operand;
    assign do_sub     = sub_reg;
    assign out_acc    = acc;
    assign out_zero   = zero_reg;
    assign out_wrap   = wrap_reg;
    assign zero_count = zcnt;

    // Next-state logic and the two handshake strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Work out the new accumulator value, wrap flag and zero flag for the latched command.
    always_comb begin
        acc_next  = acc;
        wrap_next = 1'b0;
        zero_next = zero_reg;
        case (op_reg)
            OP_ADD: begin
                acc_next  = sum;
                wrap_next = (sum < acc);
                zero_next = sum_zero;
            end
            OP_SUB: begin
                acc_next  = sum;
                wrap_next = (operand > acc);
                zero_next = sum_zero;
            end
            OP_LOAD: begin
                acc_next  = operand;
                zero_next = (operand == 8'h00);
            end
            default: begin
                acc_next  = 8'h00;
                zero_next = 1'b1;
            end
        endcase
`ifdef ADDSUB_ACC_SAT_EN
        if ((op_reg == OP_ADD || op_reg == OP_SUB) && wrap_next) begin
            acc_next = (op_reg == OP_ADD) ? 8'hFF : 8'h00;
        end
        if (op_reg == OP_ADD || op_reg == OP_SUB) begin
            zero_next = (acc_next == 8'h00);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch, accumulator/flag capture and the zero-result counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg   <= OP_ADD;
            operand  <= 8'h00;
            sub_reg  <= 1'b0;
            acc      <= 8'h00;
            zero_reg <= 1'b1;
            wrap_reg <= 1'b0;
            zcnt     <= '0;
        end else begin
            if (accept) begin
                op_reg  <= in_op;
                operand <= in_data;
                sub_reg <= (in_op == OP_SUB);
            end
            if (state == EXEC) begin
                acc      <= acc_next;
                zero_reg <= zero_next;
                wrap_reg <= wrap_next;
            end
            if (resp_done && zero_reg && !(&zcnt)) begin
                zcnt <= zcnt + ZCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Directed testbench for addsub_accum_ctrl with a small combinational model
// of the external adder/subtractor. Expectations follow ADDSUB_ACC_SAT_EN.
module tb_addsub_accum_ctrl;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       do_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       sum_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_acc;
    logic       out_zero;
    logic       out_wrap;
    logic [1:0] zero_count;

    int checks = 0;
    int errors = 0;
    int cntExp = 0;

    addsub_accum_ctrl #(.ZCNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .do_sub     (do_sub),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .sum_zero   (sum_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_zero   (out_zero),
        .out_wrap   (out_wrap),
        .zero_count (zero_count)
    );

    always #5 clk = ~clk;

    // External 8-bit adder/subtractor, modulo 256.
    always_comb begin
        sum      = do_sub ? (a - b) : (a + b);
        sum_zero = (sum == 8'h00);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command with out_ready held high and check the whole transaction.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [7:0] data,
                                 input logic [7:0] expAcc, input logic expZero,
                                 input logic expWrap, input int expCnt);
        int cntBefore;
        cntBefore = zero_count;
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = data;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_exec_valid"}, out_valid, 0);
        checkOutput({tag, "_exec_ready"}, in_ready, 0);
        checkOutput({tag, "_exec_b"}, b, data);
        checkOutput({tag, "_exec_dosub"}, do_sub, (op == OP_SUB));
        @(negedge clk);
        checkOutput({tag, "_resp_valid"}, out_valid, 1);
        checkOutput({tag, "_acc"}, out_acc, expAcc);
        checkOutput({tag, "_zero"}, out_zero, expZero);
        checkOutput({tag, "_wrap"}, out_wrap, expWrap);
        checkOutput({tag, "_cnt_hold"}, zero_count, cntBefore);
        @(negedge clk);
        checkOutput({tag, "_done_valid"}, out_valid, 0);
        checkOutput({tag, "_done_ready"}, in_ready, 1);
        checkOutput({tag, "_cnt"}, zero_count, expCnt);
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_acc", out_acc, 0);
        checkOutput("rst_out_zero", out_zero, 1);
        checkOutput("rst_out_wrap", out_wrap, 0);
        checkOutput("rst_do_sub", do_sub, 0);
        checkOutput("rst_a", a, 0);
        checkOutput("rst_b", b, 0);
        checkOutput("rst_zcnt", zero_count, 0);
        reset = 1'b0;
        #1 checkOutput("rst_release_ready", in_ready, 1);

        // Basic load/add
        applyStimulus("load10", OP_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 0);
        applyStimulus("add05", OP_ADD, 8'h05, 8'h15, 1'b0, 1'b0, 0);

        // ADD with carry
        applyStimulus("loadF0", OP_LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0, 0);
`ifdef ADDSUB_ACC_SAT_EN
        applyStimulus("add20", OP_ADD, 8'h20, 8'hFF, 1'b0, 1'b1, 0);
`else
        applyStimulus("add20", OP_ADD, 8'h20, 8'h10, 1'b0, 1'b1, 0);
`endif

        // SUB to zero, then SUB with borrow
        applyStimulus("load03", OP_LOAD, 8'h03, 8'h03, 1'b0, 1'b0, 0);
        applyStimulus("sub03", OP_SUB, 8'h03, 8'h00, 1'b1, 1'b0, 1);
`ifdef ADDSUB_ACC_SAT_EN
        applyStimulus("sub01", OP_SUB, 8'h01, 8'h00, 1'b1, 1'b1, 2);
        cntExp = 2;
`else
        applyStimulus("sub01", OP_SUB, 8'h01, 8'hFF, 1'b0, 1'b1, 1);
        cntExp = 1;
`endif

        // Backpressure: response held for 5 cycles, new command ignored
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = OP_LOAD;
        in_data   = 8'h42;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = OP_ADD;
            in_data  = 8'h01;
            checkOutput($sformatf("bp_valid_%0d", i), out_valid, 1);
            checkOutput($sformatf("bp_acc_%0d", i), out_acc, 8'h42);
            checkOutput($sformatf("bp_ready_%0d", i), in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_still_valid", out_valid, 1);
        @(negedge clk);
        checkOutput("bp_done_valid", out_valid, 0);
        checkOutput("bp_done_ready", in_ready, 1);
        checkOutput("bp_acc_kept", out_acc, 8'h42);
        checkOutput("bp_b_kept", b, 8'h42);
        checkOutput("bp_cnt", zero_count, cntExp);
        out_ready = 1'b0;

        // CLEAR 2^2+2 times: counter saturates at 3
        for (int i = 0; i < 6; i++) begin
            cntExp = (cntExp < 3) ? cntExp + 1 : 3;
            applyStimulus($sformatf("clr%0d", i), OP_CLEAR, 8'hAA, 8'h00, 1'b1, 1'b0, cntExp);
        end
        checkOutput("zcnt_saturated", zero_count, 3);

        // Reset during EXEC of ADD 0x07
        applyStimulus("load07", OP_LOAD, 8'h07, 8'h07, 1'b0, 1'b0, 3);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_data   = 8'h07;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("midrst_ready_low", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_acc", out_acc, 0);
        checkOutput("midrst_zcnt", zero_count, 0);
        checkOutput("midrst_ready", in_ready, 1);
        @(negedge clk);
        checkOutput("midrst_no_resp", out_valid, 0);
        out_ready = 1'b0;

        // LOAD 0 after reset: zero computed internally, counter restarts
        applyStimulus("load00", OP_LOAD, 8'h00, 8'h00, 1'b1, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
